// File: rtl/binary_operations_pipe_if.sv
// Handshake bundle for binary_operations_pipe: input word channel and result channel.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready follow valid-ready semantics; a beat moves when valid & ready.
// Ports: in_valid/in_ready/in_data/in_op/in_amount (upstream), out_valid/out_ready/out_data/out_err (downstream).
interface binary_operations_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int AMT_WIDTH  = $clog2(DATA_WIDTH)
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [2:0]            in_op;
    logic [AMT_WIDTH-1:0]  in_amount;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_err;

    // master: the side that produces operands and consumes results
    modport master (
        output in_valid, in_data, in_op, in_amount, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    // slave: the pipeline itself
    modport slave (
        input  in_valid, in_data, in_op, in_amount, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/binary_operations_pipe.sv
// Two-stage bitwise transform pipe: pass/invert/bit-reverse/rotate-right/byte-swap/popcount.
// Latency: 2 cycles (word accepted at edge N is on out_data after edge N+1); 1 word/cycle.
// Backpressure: S2 holds while out_valid & !out_ready; S1 holds when full; in_ready low only when both full and stalled.
// Ports: clk, reset_n (async active-low), bus (slave side of binary_operations_pipe_if).
// DATA_WIDTH must be a multiple of 8 and at least 8; AMT_WIDTH is the rotate amount width.
module binary_operations_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int AMT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    binary_operations_pipe_if.slave    bus
);
    localparam int NBYTES = DATA_WIDTH / 8;

    localparam logic [2:0] OP_NONE     = 3'b000;
    localparam logic [2:0] OP_INVERT   = 3'b001;
    localparam logic [2:0] OP_BIT_REV  = 3'b010;
    localparam logic [2:0] OP_ROT_R    = 3'b011;
    localparam logic [2:0] OP_BYTE_SWP = 3'b100;
    localparam logic [2:0] OP_POPCOUNT = 3'b101;

    // Stage 1: raw operand registers
    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic [2:0]            s1_op_q;
    logic [AMT_WIDTH-1:0]  s1_amt_q;

    // Stage 2: result registers driving the output port directly
    logic                  s2_valid_q;
    logic [DATA_WIDTH-1:0] s2_data_q;
    logic                  s2_err_q;

    logic                  s2_adv;
    logic                  s1_adv;
    logic                  in_xfer;

    logic [DATA_WIDTH-1:0] res_d;
    logic                  err_d;
    logic [DATA_WIDTH-1:0] pop_cnt;
    logic [DATA_WIDTH-1:0] bit_rev;
    logic [DATA_WIDTH-1:0] byte_swp;
    logic [DATA_WIDTH-1:0] rot_r;

    assign s2_adv  = !s2_valid_q || bus.out_ready;
    assign s1_adv  = !s1_valid_q || s2_adv;
    assign in_xfer = bus.in_valid && s1_adv;

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_err   = s2_err_q;

    // Amount 0 makes the left shift equal to the full width, which yields zero,
    // so the rotate collapses to identity without a special case.
    assign rot_r = (s1_data_q >> s1_amt_q) | (s1_data_q << (DATA_WIDTH - int'(s1_amt_q)));

    always_comb begin
        bit_rev = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            bit_rev[i] = s1_data_q[DATA_WIDTH-1-i];
        end
    end

    always_comb begin
        byte_swp = '0;
        for (int b = 0; b < NBYTES; b++) begin
            byte_swp[8*b +: 8] = s1_data_q[8*(NBYTES-1-b) +: 8];
        end
    end

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            pop_cnt = pop_cnt + {{(DATA_WIDTH-1){1'b0}}, s1_data_q[i]};
        end
    end

    always_comb begin
        res_d = '0;
        err_d = 1'b0;
        case (s1_op_q)
            OP_NONE:     res_d = s1_data_q;
            OP_INVERT:   res_d = ~s1_data_q;
            OP_BIT_REV:  res_d = bit_rev;
            OP_ROT_R:    res_d = rot_r;
            OP_BYTE_SWP: res_d = byte_swp;
            OP_POPCOUNT: res_d = pop_cnt;
            default: begin
                res_d = '0;
                err_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_op_q    <= '0;
            s1_amt_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_err_q   <= 1'b0;
        end else begin
            if (in_xfer) begin
                s1_valid_q <= 1'b1;
                s1_data_q  <= bus.in_data;
                s1_op_q    <= bus.in_op;
                s1_amt_q   <= bus.in_amount;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end

            // Result registers only change on a real word so out_data keeps its last value.
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= res_d;
                    s2_err_q  <= err_d;
                end
            end
        end
    end
endmodule

// File: doc/binary_operations_pipe.md
Name: binary_operations_pipe

Overview:
- Parametrised, pipelined successor to the PIO MOV-source operation stage.
- Applies one of several bitwise transforms to a DATA_WIDTH word: pass, invert, bit-reverse, rotate-right, byte-swap, popcount.
- Two register stages with valid/ready handshakes on both sides, so it can sit between the scratch/OSR source mux and the MOV destination write without lengthening the critical path.

Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of 8 and at least 8.
- AMT_WIDTH, $clog2(DATA_WIDTH), width of the rotate amount.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  DATA_WIDTH  operand.
- in_op  input  3  operation select.
- in_amount  input  AMT_WIDTH  rotate-right amount; ignored for other ops.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result this cycle.
- out_data  output  DATA_WIDTH  result.
- out_err  output  1  result came from a reserved op code; qualified by out_valid.

Behaviour:
- Op codes:
  - 000 NONE: out = in.
  - 001 INVERT: bitwise NOT.
  - 010 BIT_REVERSE: out[i] = in[DATA_WIDTH-1-i].
  - 011 ROTATE_RIGHT: rotate right by in_amount; amount 0 is identity.
  - 100 BYTE_SWAP: byte order reversed; bits within each byte unchanged.
  - 101 POPCOUNT: count of 1 bits, zero-extended to DATA_WIDTH.
  - 110, 111 reserved: out_data = 0, out_err = 1.
- Stage 1 (S1) registers in_data, in_op and in_amount plus s1_valid. Stage 2 (S2) registers the computed result, the err flag and s2_valid.
- All transform logic sits between S1 and S2. None sits on the input or output ports.
- Handshake equations:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv
- Input transfer: in_valid & in_ready.
  - On transfer, S1 loads and s1_valid <= 1.
  - Else if s1_adv, s1_valid <= 0.
- S2 loads when s2_adv: s2_valid <= s1_valid; data/err loaded only if s1_valid.
- Latency: a word accepted at edge N appears on out_valid/out_data after edge N+1, provided out_ready stayed high. This gives 2-cycle latency and throughput of 1 word per cycle.
- Backpressure: while out_valid & !out_ready, out_data and out_err hold stable and S2 does not change.
  - S1 holds if it is full.
  - in_ready falls only when both stages are full and out_ready = 0.
  - No word is dropped or duplicated.
- Simultaneous events:
  - Full pipeline with out_ready = 1: a new input is accepted in the same cycle as the output drains.
  - in_valid with in_ready = 0: input ignored; upstream must hold it.
- Reset (async assert, any time, including mid-transfer): s1_valid = s2_valid = 0, all data/op/err registers = 0, out_valid = 0, out_err = 0, out_data = 0, in_ready = 1.
- Output values while out_valid = 0 are don't-care for consumers, but out_data holds its last value; it is 0 after reset.

Test Plan:
- Reset, then in_valid=1, in_op=000/001/010, in_data=0x0000_0001 with out_ready=1 -> 2 cycles later out_data = 0x0000_0001, then 0xFFFF_FFFE, then 0x8000_0000 on consecutive cycles, out_err=0.
- ROTATE_RIGHT: in_data=0x0000_00F1 with in_amount=4 -> 0x1000_000F. Amount 0 -> 0x0000_00F1. Amount 31 -> 0x0000_01E2.
- BYTE_SWAP 0x1234_5678 -> 0x7856_3412. POPCOUNT 0xFFFF_FFFF -> 0x0000_0020. POPCOUNT 0 -> 0.
- Reserved op 110 with in_data=0xDEAD_BEEF -> out_data=0, out_err=1. The following op 000 word gives out_err=0.
- Backpressure: stream 4 words 1..4 (op 000) with out_ready held 0 -> in_ready drops after 2 accepted, out_data stays 1. Release out_ready -> outputs 1,2,3,4 in order, no gaps once streaming, no loss.
- Assert reset_n=0 mid-stream with both stages full -> out_valid=0 and in_ready=1 immediately (asynchronously). After release, the first new word emerges 2 cycles after acceptance, and pre-reset words never appear.
- Rerun with DATA_WIDTH=16: BIT_REVERSE 0x0001 -> 0x8000. POPCOUNT 0xFFFF -> 0x0010.
